// File: rtl/cnn_img_loader.sv
`default_nettype none
// ============================================================================
// cnn_img_loader : packs a valid/ready pixel stream into a frame for the CNN core
// Optional IMG_TLAST_CHECK_EN enables s_last framing checks.  Rev 1.0
// ============================================================================
module cnn_img_loader #(
  parameter int DATA_W     = 32,
  parameter int IMG_PIXELS = 64,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_last,
  output logic [DATA_W*IMG_PIXELS-1:0] img_flat,
  output logic                         core_enable,
  output logic                         core_rst,
  input  logic                         core_done,
  output logic                         busy,
  output logic [CNT_W-1:0]             frame_count,
  output logic                         frame_err
);

  localparam int               IDX_W    = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_REARM = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [DATA_W*IMG_PIXELS-1:0] img_q, img_d;
  logic                         s_ready_q, s_ready_d;
  logic                         core_enable_q, core_enable_d;
  logic                         core_rst_q, core_rst_d;
  logic                         busy_q, busy_d;
  logic [CNT_W-1:0]             frame_count_q, frame_count_d;
  logic                         frame_err_q, frame_err_d;

  logic beat;
  logic last_bad;

  assign beat = s_valid & s_ready_q;

`ifdef IMG_TLAST_CHECK_EN
  assign last_bad = s_last != (idx_q == LAST_IDX);
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign last_bad      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    img_d         = img_q;
    frame_count_d = frame_count_q;
    frame_err_d   = frame_err_q;

    case (state_q)
      ST_LOAD: begin
        if (beat) begin
          if (last_bad) begin
            // Malformed frame: drop what was collected and resynchronise.
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            img_d[idx_q*DATA_W +: DATA_W] = s_data;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = ST_READY;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      ST_READY: state_d = ST_RUN;
      ST_RUN: begin
        if (core_done) begin
          state_d       = ST_REARM;
          frame_count_d = frame_count_q + 1'b1;
        end
      end
      ST_REARM: state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase

    // Outputs are registered from the next state so they line up with it.
    s_ready_d     = (state_d == ST_LOAD);
    core_enable_d = (state_d == ST_RUN);
    core_rst_d    = (state_d == ST_REARM);
    busy_d        = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      idx_q         <= '0;
      img_q         <= '0;
      s_ready_q     <= 1'b0;
      core_enable_q <= 1'b0;
      core_rst_q    <= 1'b1;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      img_q         <= img_d;
      s_ready_q     <= s_ready_d;
      core_enable_q <= core_enable_d;
      core_rst_q    <= core_rst_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign img_flat    = img_q;
  assign core_enable = core_enable_q;
  assign core_rst    = core_rst_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign frame_err   = frame_err_q;

endmodule
`default_nettype wire
